// File: rtl/pwm_pkg.sv
// Shared types and constant helpers for the centre-aligned PWM block.
package pwm_pkg;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;

    // Compare value that represents 1.0 for the given fractional precision.
    function automatic int unsigned pwm_one(input int unsigned frac_bits);
        return 32'd1 << frac_bits;
    endfunction

    // Full-scale compare value (2.0), also the triangle turnaround height.
    function automatic int unsigned pwm_max(input int unsigned frac_bits);
        return 32'd2 << frac_bits;
    endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Per-phase dead-time inserter: a gate turns on only after its level has
// been held for DEADTIME cycles and drops the moment the level changes.
// The input is the phase level for the coming cycle, so the registered
// gates line up with the raw phase rather than trailing it.
module pwm_deadtime #(
    parameter int unsigned DEADTIME = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic p,
    output logic pwm_h,
    output logic pwm_l
);

    localparam int unsigned RW = (DEADTIME == 0) ? 1 : $clog2(DEADTIME + 1);
    localparam logic [RW-1:0] DT = RW'(DEADTIME);

    logic [RW-1:0] run_q;
    logic [RW-1:0] prior_c;
    logic [RW-1:0] run_d;
    logic          level_q;
    logic          seen_q;
    logic          same_c;

    // Count of earlier consecutive cycles at the current level, saturating.
    always_comb begin
        same_c  = seen_q && (p == level_q);
        prior_c = same_c ? run_q : '0;
        run_d   = (prior_c == DT) ? DT : prior_c + RW'(1);
    end

    // Run tracking and gate registers; disable wipes the history.
    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            run_q   <= '0;
            level_q <= 1'b0;
            seen_q  <= 1'b0;
            pwm_h   <= 1'b0;
            pwm_l   <= 1'b0;
        end else begin
            run_q   <= run_d;
            level_q <= p;
            seen_q  <= 1'b1;
            pwm_h   <= p && (prior_c >= DT);
            pwm_l   <= !p && (prior_c >= DT);
        end
    end

endmodule

// File: rtl/pwm_center_3ph.sv
// Centre-aligned three-phase PWM: triangle carrier, double-buffered
// compare values applied at the period boundary, dead-time gate drive.
module pwm_center_3ph
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH           = 10,
    parameter int unsigned FRACTIONAL_BITS = 8,
    parameter int unsigned DEADTIME        = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic signed [WIDTH-1:0] c,
    output logic [2:0]              pwm_h,
    output logic [2:0]              pwm_l,
    output logic                    period_start,
    output logic [2:0]              sat
);

    localparam int unsigned ONE = pwm_one(FRACTIONAL_BITS);
    localparam int unsigned MAX = pwm_max(FRACTIONAL_BITS);
    localparam int unsigned CW  = FRACTIONAL_BITS + 1;
    localparam int unsigned PW  = FRACTIONAL_BITS + 2;
    localparam int unsigned XW  = WIDTH + 1;

    localparam logic signed [XW-1:0] ONE_S   = XW'(ONE);
    localparam logic [CW-1:0]        CNT_TOP = CW'(MAX - 1);
    localparam logic [PW-1:0]        CMP_ONE = PW'(ONE);

    // Clamp to [-1, +1] and offset into 0..MAX; returns {sat, cmp}.
    function automatic logic [PW:0] map_cmp(input logic signed [WIDTH-1:0] x);
        logic signed [XW-1:0] xs;
        logic signed [XW-1:0] sum;
        logic                 s;
        xs = XW'(x);
        s  = 1'b0;
        if (xs > ONE_S) begin
            xs = ONE_S;
            s  = 1'b1;
        end else if (xs < -ONE_S) begin
            xs = -ONE_S;
            s  = 1'b1;
        end
        sum = xs + ONE_S;
        return {s, sum[PW-1:0]};
    endfunction

    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    dir_e                   dir_q;
    dir_e                   dir_d;
    logic                   running_q;
    logic                   running_d;
    logic                   load_c;
    logic                   ps_d;

    logic [2:0][PW-1:0]     pend_cmp_q;
    logic [2:0]             pend_sat_q;
    logic                   pend_flag_q;
    logic [2:0][PW-1:0]     act_cmp_q;

    logic signed [WIDTH-1:0] x_c [3];
    logic [2:0][PW-1:0]     new_cmp_c;
    logic [2:0]             new_sat_c;
    logic [2:0]             p_c;
    logic                   dt_en_c;

    assign x_c[0] = a;
    assign x_c[1] = b;
    assign x_c[2] = c;

    // Map incoming references to compare values and saturation flags.
    always_comb begin
        new_cmp_c = '0;
        new_sat_c = '0;
        for (int i = 0; i < 3; i++) begin
            {new_sat_c[i], new_cmp_c[i]} = map_cmp(x_c[i]);
        end
    end

    // Carrier next state; the first enabled cycle acts as a boundary so the
    // period starts cleanly at zero with any pending value applied.
    always_comb begin
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        running_d = running_q;
        load_c    = 1'b0;
        ps_d      = 1'b0;
        if (!enable) begin
            cnt_d     = '0;
            dir_d     = UP;
            running_d = 1'b0;
        end else if (!running_q) begin
            running_d = 1'b1;
            load_c    = 1'b1;
            ps_d      = 1'b1;
        end else begin
            case (dir_q)
                UP: begin
                    if (cnt_q == CNT_TOP) begin
                        dir_d = DOWN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DOWN: begin
                    if (cnt_q == '0) begin
                        dir_d  = UP;
                        load_c = 1'b1;
                        ps_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    dir_d = UP;
                end
            endcase
        end
    end

    // Carrier state and period strobe registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            dir_q        <= UP;
            running_q    <= 1'b0;
            period_start <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            running_q    <= running_d;
            period_start <= ps_d;
        end
    end

    // Shadow buffer: latest write wins; a write on the boundary bypasses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_cmp_q  <= {3{CMP_ONE}};
            pend_sat_q  <= '0;
            pend_flag_q <= 1'b0;
            act_cmp_q   <= {3{CMP_ONE}};
            sat         <= '0;
        end else if (load_c) begin
            if (in_valid) begin
                act_cmp_q <= new_cmp_c;
                sat       <= new_sat_c;
            end else if (pend_flag_q) begin
                act_cmp_q <= pend_cmp_q;
                sat       <= pend_sat_q;
            end
            pend_flag_q <= 1'b0;
        end else if (in_valid) begin
            pend_cmp_q  <= new_cmp_c;
            pend_sat_q  <= new_sat_c;
            pend_flag_q <= 1'b1;
        end
    end

    // Raw phase level for the coming cycle: high while carrier is below cmp.
    always_comb begin
        p_c = '0;
        for (int i = 0; i < 3; i++) begin
            p_c[i] = PW'(cnt_q) < act_cmp_q[i];
        end
    end

    assign dt_en_c = enable && running_q;

    for (genvar i = 0; i < 3; i++) begin : g_phase
        pwm_deadtime #(
            .DEADTIME (DEADTIME)
        ) u_dt (
            .clk    (clk),
            .rst_n  (rst_n),
            .enable (dt_en_c),
            .p      (p_c[i]),
            .pwm_h  (pwm_h[i]),
            .pwm_l  (pwm_l[i])
        );
    end

endmodule

// File: tb/tb_pwm_center_3ph.sv
// Scoreboard bench for pwm_center_3ph: a period/position reference model
// predicts every output cycle, plus directed per-period duty counts.
module tb_pwm_center_3ph;

    localparam int ONE = 256;
    localparam int MAX = 512;
    localparam int PER = 1024;
    localparam int DT  = 4;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic              in_valid;
    logic signed [9:0] a;
    logic signed [9:0] b;
    logic signed [9:0] c;
    logic [2:0]        pwm_h;
    logic [2:0]        pwm_l;
    logic              period_start;
    logic [2:0]        sat;

    int checks;
    int errors;

    pwm_center_3ph #(
        .WIDTH           (10),
        .FRACTIONAL_BITS (8),
        .DEADTIME        (DT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .in_valid     (in_valid),
        .a            (a),
        .b            (b),
        .c            (c),
        .pwm_h        (pwm_h),
        .pwm_l        (pwm_l),
        .period_start (period_start),
        .sat          (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          k_m;
    bit          run_m;
    int          act_m [3];
    int          pend_m [3];
    bit [2:0]    sat_m;
    bit [2:0]    psat_m;
    bit          pflag_m;
    bit [DT:0]   hb [3];
    int          hl [3];
    logic [9:0]  exp_q [$];

    function automatic int clamp_cmp(input int x);
        if (x > ONE) return 2 * ONE;
        if (x < -ONE) return 0;
        return x + ONE;
    endfunction

    function automatic bit is_sat(input int x);
        return (x > ONE) || (x < -ONE);
    endfunction

    // Predict the outputs following each rising edge from the spec's rules.
    always @(posedge clk) begin
        int       xin [3];
        int       tv;
        bit       v;
        bit       bnd;
        bit [2:0] eh;
        bit [2:0] el;
        bit       eps;
        xin[0] = int'(a);
        xin[1] = int'(b);
        xin[2] = int'(c);
        eh  = '0;
        el  = '0;
        eps = 1'b0;
        if (!rst_n) begin
            k_m = 0; run_m = 0; pflag_m = 0; sat_m = '0; psat_m = '0;
            for (int i = 0; i < 3; i++) begin
                act_m[i] = ONE; pend_m[i] = ONE; hb[i] = '0; hl[i] = 0;
            end
        end else if (!enable) begin
            k_m = 0; run_m = 0;
            for (int i = 0; i < 3; i++) begin hb[i] = '0; hl[i] = 0; end
            if (in_valid) begin
                for (int i = 0; i < 3; i++) begin
                    pend_m[i] = clamp_cmp(xin[i]); psat_m[i] = is_sat(xin[i]);
                end
                pflag_m = 1;
            end
        end else begin
            if (run_m) begin
                tv = (k_m < MAX) ? k_m : (PER - 1 - k_m);
                for (int i = 0; i < 3; i++) begin
                    v = (tv < act_m[i]);
                    hb[i] = {hb[i][DT-1:0], v};
                    hl[i] = (hl[i] < DT + 1) ? hl[i] + 1 : DT + 1;
                    eh[i] = (hl[i] == DT + 1) && (&hb[i]);
                    el[i] = (hl[i] == DT + 1) && (hb[i] == '0);
                end
                bnd = (k_m == PER - 1);
            end else begin
                for (int i = 0; i < 3; i++) begin hb[i] = '0; hl[i] = 0; end
                bnd = 1;
            end
            if (bnd) begin
                if (in_valid) begin
                    for (int i = 0; i < 3; i++) begin
                        act_m[i] = clamp_cmp(xin[i]); sat_m[i] = is_sat(xin[i]);
                    end
                end else if (pflag_m) begin
                    for (int i = 0; i < 3; i++) act_m[i] = pend_m[i];
                    sat_m = psat_m;
                end
                pflag_m = 0; k_m = 0; run_m = 1; eps = 1;
            end else begin
                if (in_valid) begin
                    for (int i = 0; i < 3; i++) begin
                        pend_m[i] = clamp_cmp(xin[i]); psat_m[i] = is_sat(xin[i]);
                    end
                    pflag_m = 1;
                end
                k_m++;
            end
        end
        exp_q.push_back({eps, sat_m, el, eh});
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [9:0] e;
        logic [9:0] g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {period_start, sat, pwm_l, pwm_h};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL outputs @%0t: got ps=%b sat=%b l=%b h=%b, want ps=%b sat=%b l=%b h=%b",
                         $time, g[9], g[8:6], g[5:3], g[2:0], e[9], e[8:6], e[5:3], e[2:0]);
            end
            checks++;
            if ((pwm_h & pwm_l) != 3'b000) begin
                errors++;
                $display("FAIL overlap @%0t: h=%b l=%b, want no common bit", $time, pwm_h, pwm_l);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int hc [3];
    int lc [3];
    int nps;

    task automatic check_eq(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic send(input int xa, input int xb, input int xc);
        in_valid = 1'b1;
        a = 10'(xa); b = 10'(xb); c = 10'(xc);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_ps();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (period_start !== 1'b1 && n < 3000);
        if (period_start !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL period_start timeout: got none in %0d cycles, want one", n);
        end
    endtask

    // Count gate high cycles over one period starting at the current cycle.
    task automatic measure();
        for (int i = 0; i < 3; i++) begin hc[i] = 0; lc[i] = 0; end
        nps = 0;
        for (int n = 0; n < PER; n++) begin
            if (n > 0) @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                hc[i] += int'(pwm_h[i]);
                lc[i] += int'(pwm_l[i]);
            end
            nps += int'(period_start);
        end
    endtask

    task automatic stimulus();
        rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; a = '0; b = '0; c = '0;
        repeat (3) @(negedge clk);
        check_eq("reset outputs", int'({period_start, sat, pwm_l, pwm_h}), 0);

        // 1: 50% duty on all phases
        rst_n = 1'b1; enable = 1'b1;
        send(0, 0, 0);
        wait_ps(); wait_ps();
        measure();
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("sc1 pwm_h ph%0d", i), hc[i], 508);
            check_eq($sformatf("sc1 pwm_l ph%0d", i), lc[i], 508);
        end
        check_eq("sc1 strobes per period", nps, 1);
        @(negedge clk);
        check_eq("sc1 period length", int'(period_start), 1);

        // 2: saturation and full-scale compares
        send(400, -300, 128);
        wait_ps(); wait_ps();
        check_eq("sc2 sat", int'(sat), 3);
        measure();
        check_eq("sc2 A pwm_h", hc[0], 1024);
        check_eq("sc2 A pwm_l", lc[0], 0);
        check_eq("sc2 B pwm_h", hc[1], 0);
        check_eq("sc2 B pwm_l", lc[1], 1024);
        check_eq("sc2 C pwm_h", hc[2], 764);
        check_eq("sc2 C pwm_l", lc[2], 252);

        // 3: two mid-period writes, latest wins at next boundary
        wait_ps();
        repeat (100) @(negedge clk);
        send(0, 0, 0);
        repeat (499) @(negedge clk);
        send(-128, 0, 0);
        wait_ps();
        measure();
        check_eq("sc3 A pwm_h", hc[0], 252);

        // 4: write on the load cycle bypasses into the next period
        wait_ps();
        repeat (1023) @(negedge clk);
        in_valid = 1'b1; a = 10'(64); b = '0; c = '0;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("sc4 strobe after bypass", int'(period_start), 1);
        measure();
        check_eq("sc4 A pwm_h", hc[0], 636);

        // 5: pulse no longer than dead time is suppressed
        send(-254, 0, 0);
        wait_ps(); wait_ps();
        measure();
        check_eq("sc5 A pwm_h", hc[0], 0);
        check_eq("sc5 A pwm_l", lc[0], 1016);

        // 6: mid-period reset, then mid-period disable and re-enable
        wait_ps();
        repeat (300) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("sc6 reset outputs", int'({period_start, sat, pwm_l, pwm_h}), 0);
        rst_n = 1'b1;
        wait_ps(); wait_ps();
        measure();
        check_eq("sc6 A pwm_h after reset", hc[0], 508);
        check_eq("sc6 B pwm_l after reset", lc[1], 508);
        repeat (200) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check_eq("sc6 gates off", int'({pwm_l, pwm_h}), 0);
        send(-128, 0, 0);
        repeat (20) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check_eq("sc6 strobe on re-enable", int'(period_start), 1);
        wait_ps();
        measure();
        check_eq("sc6 A pwm_h pending loaded", hc[0], 252);

        // random writes and enable drops, checked by the model
        for (int n = 0; n < 9000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                if ($urandom_range(0, 3) == 0)
                    send(int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512,
                         int'($urandom_range(0, 1023)) - 512);
                else
                    send(int'($urandom_range(0, 600)) - 300, int'($urandom_range(0, 600)) - 300,
                         int'($urandom_range(0, 600)) - 300);
            end else if ($urandom_range(0, 2999) == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 30)) @(negedge clk);
                enable = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        fork
            stimulus();
            wait (errors > 100);
        join_any
        disable fork;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
